// File: rtl/ds_reg_bridge_if.sv
// Host-side pin bundle of the delta-sigma register bridge.
interface ds_reg_bridge_if #(
  parameter int ADDR_BITS = 3
);
  logic [7:0]           data_in;
  logic [ADDR_BITS-1:0] addr_in;
  logic                 sel_in;
  logic                 strobe_in;
  logic [7:0]           rd_data;
  logic                 ack_toggle;
  logic                 err;

  modport master (
    output data_in, addr_in, sel_in, strobe_in,
    input  rd_data, ack_toggle, err
  );

  modport slave (
    input  data_in, addr_in, sel_in, strobe_in,
    output rd_data, ack_toggle, err
  );
endinterface

// File: rtl/ds_reg_bridge.sv
// Byte-serial host writes from async pins assembled into DATA_W-bit words and
// committed to a small register file with auto-increment, self-clear and readback.
module ds_reg_bridge_cell #(
  parameter int                DATA_W  = 16,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter logic [DATA_W-1:0] MASK    = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr,
  output logic [DATA_W-1:0] q
);
  // A commit in the same cycle as a clear wins, unmasked.
  always_ff @(posedge clk) begin
    if (reset)      q <= RST_VAL;
    else if (wr_en) q <= wr_data;
    else if (clr)   q <= q & ~MASK;
  end
endmodule

module ds_reg_bridge #(
  parameter int DATA_W      = 16,
  parameter int NUM_REGS    = 3,
  parameter int ADDR_BITS   = 3,
  parameter int SYNC_STAGES = 2,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALUES = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] CLEAR_MASK   = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  ds_reg_bridge_if.slave               host,
  input  logic [NUM_REGS-1:0]          clear_event,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic [NUM_REGS-1:0]          write_pulse
);
  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(BYTES - 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_REGS - 1);
  localparam logic [ADDR_BITS:0]   NREGS     = (ADDR_BITS + 1)'(NUM_REGS);

  typedef enum logic {IDLE, COLLECT} state_t;

  // Chains and strobe_prev run through reset so no phantom edge appears on release.
  logic [SYNC_STAGES-1:0] sel_sync, strobe_sync;
  logic sel_s, strobe_s, strobe_prev, byte_ev;

  always_ff @(posedge clk) begin
    sel_sync    <= {sel_sync[SYNC_STAGES-2:0], host.sel_in};
    strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], host.strobe_in};
    strobe_prev <= strobe_s;
  end

  assign sel_s    = sel_sync[SYNC_STAGES-1];
  assign strobe_s = strobe_sync[SYNC_STAGES-1];
  assign byte_ev  = strobe_s ^ strobe_prev;

  state_t                          state, state_nx;
  logic [IDX_W-1:0]                byte_idx, byte_idx_nx;
  logic [ADDR_BITS-1:0]            cur_addr, cur_addr_nx, wr_addr, ra;
  logic                            first_word, first_word_nx;
  logic [DATA_W-1:0]               shadow, shadow_nx, word, rd_word;
  logic                            wr_ok, commit, err_set;
  logic                            err_q, ack_q;
  logic [7:0]                      rd_q, rd_nx;
  logic [NUM_REGS-1:0]             wp_nx;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  always_comb begin
    state_nx      = state;
    byte_idx_nx   = byte_idx;
    cur_addr_nx   = cur_addr;
    first_word_nx = first_word;
    shadow_nx     = shadow;
    commit        = 1'b0;
    err_set       = 1'b0;
    // Start address is taken live from the pins on the first byte of a frame.
    wr_addr = (byte_idx == '0 && first_word) ? host.addr_in : cur_addr;
    word    = shadow;
    word[{byte_idx, 3'b000} +: 8] = host.data_in;
    wr_ok   = {1'b0, wr_addr} < NREGS;
    case (state)
      IDLE: begin
        byte_idx_nx = '0;
        if (sel_s) begin
          state_nx      = COLLECT;
          first_word_nx = 1'b1;
        end
      end
      COLLECT: begin
        if (!sel_s) begin
          state_nx    = IDLE;
          byte_idx_nx = '0;
          err_set     = (byte_idx != '0);
        end else if (byte_ev) begin
          shadow_nx = word;
          if (byte_idx == LAST_IDX) begin
            byte_idx_nx   = '0;
            first_word_nx = 1'b0;
            commit        = wr_ok;
            err_set       = !wr_ok;
            cur_addr_nx   = (wr_addr == LAST_ADDR) ? '0 : wr_addr + 1'b1;
          end else begin
            byte_idx_nx = byte_idx + 1'b1;
            cur_addr_nx = wr_addr;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    wp_nx   = '0;
    rd_word = '0;
    ra      = (state == COLLECT) ? cur_addr : host.addr_in;
    for (int i = 0; i < NUM_REGS; i++) begin
      wp_nx[i] = commit && (wr_addr == ADDR_BITS'(i));
      if (ra == ADDR_BITS'(i)) rd_word = regs[i];
    end
    rd_nx = rd_word[{byte_idx, 3'b000} +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      byte_idx    <= '0;
      cur_addr    <= '0;
      first_word  <= 1'b0;
      shadow      <= '0;
      err_q       <= 1'b0;
      ack_q       <= 1'b0;
      rd_q        <= '0;
      write_pulse <= '0;
    end else begin
      state       <= state_nx;
      byte_idx    <= byte_idx_nx;
      cur_addr    <= cur_addr_nx;
      first_word  <= first_word_nx;
      shadow      <= shadow_nx;
      err_q       <= err_q | err_set;
      ack_q       <= ack_q ^ commit;
      rd_q        <= rd_nx;
      write_pulse <= wp_nx;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    ds_reg_bridge_cell #(
      .DATA_W  (DATA_W),
      .RST_VAL (RESET_VALUES[g*DATA_W +: DATA_W]),
      .MASK    (CLEAR_MASK[g*DATA_W +: DATA_W])
    ) u_cell (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wp_nx[g]),
      .wr_data (word),
      .clr     (clear_event[g]),
      .q       (regs[g])
    );
    assign regs_out[g*DATA_W +: DATA_W] = regs[g];
  end

  assign host.rd_data    = rd_q;
  assign host.ack_toggle = ack_q;
  assign host.err        = err_q;
endmodule

// File: tb/tb_ds_reg_bridge.sv
// Bench for ds_reg_bridge: vector table, hand corner sequences, random frames vs a frame-level model.
module tb_ds_reg_bridge;
  localparam int DW = 16, NR = 3, AB = 3, SS = 2, BY = DW / 8;
  localparam logic [NR*DW-1:0] RV = {16'h8000, 16'h0700, 16'h0000};
  localparam logic [NR*DW-1:0] CM = {16'h0001, 16'h1000, 16'h00F0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NR-1:0]    clear_event = '0;
  logic [NR*DW-1:0] regs_out;
  logic [NR-1:0]    write_pulse;

  ds_reg_bridge_if #(.ADDR_BITS(AB)) host();

  ds_reg_bridge #(
    .DATA_W(DW), .NUM_REGS(NR), .ADDR_BITS(AB), .SYNC_STAGES(SS),
    .RESET_VALUES(RV), .CLEAR_MASK(CM)
  ) dut (
    .clk(clk), .reset(reset), .host(host),
    .clear_event(clear_event), .regs_out(regs_out), .write_pulse(write_pulse)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int wp_cnt[NR] = '{default: 0};
  int wp_base[NR];
  int ack_cnt = 0, ack_base;
  logic ack_prev = 1'b0;

  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) if (write_pulse[i] === 1'b1) wp_cnt[i]++;
    if (!reset && host.ack_toggle !== ack_prev) ack_cnt++;
    ack_prev = host.ack_toggle;
  end

  // Frame-level reference model
  logic [DW-1:0] m_regs[NR];
  logic [DW-1:0] m_buf;
  logic m_err;
  int m_addr, m_cnt, m_commits;
  int m_wp[NR];
  bit m_inframe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    ack_base = ack_cnt;
    wp_base  = wp_cnt;
    m_commits = 0;
    for (int i = 0; i < NR; i++) m_wp[i] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    host.sel_in = 1'b0;
    clear_event = '0;
    tick(SS + 3);
    reset = 1'b0;
    tick(2);
    for (int i = 0; i < NR; i++) m_regs[i] = RV[i*DW +: DW];
    m_err = 1'b0; m_addr = 0; m_cnt = 0; m_inframe = 0;
    snap();
  endtask

  task automatic model_byte(input logic [7:0] b);
    m_buf[m_cnt*8 +: 8] = b;
    m_cnt++;
    if (m_cnt == BY) begin
      if (m_addr < NR) begin
        m_regs[m_addr] = m_buf;
        m_commits++;
        m_wp[m_addr]++;
      end else m_err = 1'b1;
      m_addr = (m_addr == NR - 1) ? 0 : (m_addr + 1) % (1 << AB);
      m_cnt = 0;
    end
  endtask

  task automatic open_frame(input int a);
    host.addr_in = a[AB-1:0];
    host.sel_in  = 1'b1;
    tick(SS + 2);
    m_addr = a; m_cnt = 0; m_inframe = 1;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    host.data_in   = b;
    host.strobe_in = ~host.strobe_in;
    model_byte(b);
  endtask

  task automatic send_byte(input logic [7:0] b);
    drive_byte(b);
    tick(SS + 4);
  endtask

  task automatic close_frame();
    host.sel_in = 1'b0;
    tick(SS + 3);
    if (m_cnt != 0) m_err = 1'b1;
    m_cnt = 0; m_inframe = 0;
  endtask

  function automatic logic [7:0] exp_rd();
    int a;
    a = m_inframe ? m_addr : int'(host.addr_in);
    if (a >= NR) return 8'h00;
    return m_regs[a][(m_inframe ? m_cnt : 0)*8 +: 8];
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("%s reg%0d", tag, i), regs_out[i*DW +: DW], m_regs[i]);
      chk($sformatf("%s wp%0d", tag, i), wp_cnt[i] - wp_base[i], m_wp[i]);
    end
    chk({tag, " err"}, host.err, m_err);
    chk({tag, " acks"}, ack_cnt - ack_base, m_commits);
  endtask

  typedef struct {
    bit          rst;
    int          addr;
    int          n;
    logic [47:0] bytes;
    logic [15:0] e0, e1, e2;
    bit          e_err;
    int          e_acks;
  } vec_t;

  vec_t vecs[5];

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1, 1, 2, 48'h1234,          16'h0000, 16'h1234, 16'h0000 | 16'h8000, 0, 1};
    vecs[1] = '{1, 1, 6, 48'hFFEEDDCCBBAA,  16'hFFEE, 16'hBBAA, 16'hDDCC, 0, 3};
    vecs[2] = '{1, 0, 1, 48'h55,            16'h0000, 16'h0700, 16'h8000, 1, 0};
    vecs[3] = '{1, 5, 2, 48'h2211,          16'h0000, 16'h0700, 16'h8000, 1, 0};
    vecs[4] = '{0, 2, 2, 48'h5678,          16'h0000, 16'h0700, 16'h5678, 1, 1};

    host.data_in = '0; host.addr_in = '0; host.sel_in = 1'b0; host.strobe_in = 1'b1;

    // Reset image, strobe pin held high throughout
    reset = 1'b1;
    tick(SS + 4);
    for (int i = 0; i < NR; i++) chk($sformatf("rst reg%0d", i), regs_out[i*DW +: DW], RV[i*DW +: DW]);
    chk("rst write_pulse", write_pulse, 0);
    chk("rst err", host.err, 0);
    chk("rst rd_data", host.rd_data, 0);
    chk("rst ack", host.ack_toggle, 0);
    reset = 1'b0;
    tick(SS + 4);
    chk("post-rst ack", host.ack_toggle, 0);
    chk("post-rst wp", wp_cnt[0] + wp_cnt[1] + wp_cnt[2], 0);

    // Vector table
    for (int r = 0; r < 5; r++) begin
      int wsum;
      if (vecs[r].rst) do_reset();
      else snap();
      open_frame(vecs[r].addr);
      for (int k = 0; k < vecs[r].n; k++) send_byte(vecs[r].bytes[k*8 +: 8]);
      close_frame();
      chk($sformatf("row%0d reg0", r), regs_out[0 +: DW], vecs[r].e0);
      chk($sformatf("row%0d reg1", r), regs_out[DW +: DW], vecs[r].e1);
      chk($sformatf("row%0d reg2", r), regs_out[2*DW +: DW], vecs[r].e2);
      chk($sformatf("row%0d err", r), host.err, vecs[r].e_err);
      chk($sformatf("row%0d acks", r), ack_cnt - ack_base, vecs[r].e_acks);
      wsum = 0;
      for (int i = 0; i < NR; i++) wsum += wp_cnt[i] - wp_base[i];
      chk($sformatf("row%0d wp cycles", r), wsum, vecs[r].e_acks);
    end

    // Self-clear, then clear coincident with a commit
    do_reset();
    open_frame(1); send_byte(8'h00); send_byte(8'h17); close_frame();
    chk("clr pre", regs_out[DW +: DW], 16'h1700);
    clear_event = 3'b010; tick(1); clear_event = '0; tick(2);
    chk("clr reg1", regs_out[DW +: DW], 16'h0700);
    chk("clr reg2 kept", regs_out[2*DW +: DW], 16'h8000);
    open_frame(1); send_byte(8'h34);
    drive_byte(8'h12);
    tick(SS);
    clear_event = 3'b010; tick(1); clear_event = '0;
    tick(SS + 3);
    chk("clr+commit reg1", regs_out[DW +: DW], 16'h1234);
    close_frame();

    // Readback in IDLE and mid-frame
    do_reset();
    host.addr_in = 3'd2; tick(2);
    chk("rd idle addr2", host.rd_data, 8'h00);
    open_frame(2); send_byte(8'h11);
    chk("rd after 1 byte", host.rd_data, 8'h80);
    close_frame();
    chk("rd partial err", host.err, 1);

    // Randomized frames against the model
    do_reset();
    for (int f = 0; f < 40; f++) begin
      int a, n;
      a = ($urandom_range(0, 7) < 6) ? $urandom_range(0, NR - 1) : $urandom_range(NR, 7);
      n = $urandom_range(1, 7);
      open_frame(a);
      for (int k = 0; k < n; k++) begin
        send_byte(8'($urandom));
        if (k == 0) host.addr_in = 3'($urandom);
        chk($sformatf("rnd f%0d b%0d rd", f, k), host.rd_data, exp_rd());
        if ($urandom_range(0, 3) == 0) begin
          logic [NR-1:0] cm;
          cm = NR'($urandom);
          clear_event = cm; tick(1); clear_event = '0; tick(2);
          for (int i = 0; i < NR; i++) if (cm[i]) m_regs[i] &= ~CM[i*DW +: DW];
        end
      end
      close_frame();
      check_all($sformatf("rnd f%0d", f));
      chk($sformatf("rnd f%0d idle rd", f), host.rd_data, exp_rd());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ds_reg_bridge.md
# ds_reg_bridge

Parametrised host-to-register bridge for the delta-sigma DAC family. It receives byte-serial writes from slow, asynchronous host pins. It assembles the bytes into DATA_W-bit words and commits them to a register file of NUM_REGS entries, with address auto-increment. It supports per-bit hardware self-clear, registered byte readback, and a sticky framing-error flag. It sits between the chip pins and the modulator/divider configuration inputs, and replaces the fixed two-phase 16-bit write scheme.

## Interface
- DATA_W, 16: register width; multiple of 8; BYTES = DATA_W/8.
- NUM_REGS, 3: number of registers.
- ADDR_BITS, 3: address width; 2^ADDR_BITS >= NUM_REGS.
- SYNC_STAGES, 2: synchroniser depth for sel_in and strobe_in; minimum 2.
- RESET_VALUES, 0: packed NUM_REGS*DATA_W reset image; register i occupies [i*DATA_W +: DATA_W].
- CLEAR_MASK, 0: packed NUM_REGS*DATA_W; set bits are cleared by clear_event[i].

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- data_in  in  8  byte from host; stable from before strobe toggle until SYNC_STAGES+2 cycles after.
- addr_in  in  ADDR_BITS  start address; sampled at the first byte of a frame.
- sel_in  in  1  async frame select; high = frame open.
- strobe_in  in  1  async byte strobe; every edge (rise or fall) = one byte.
- clear_event  in  NUM_REGS  one-cycle pulses; clear CLEAR_MASK bits of register i.
- regs_out  out  NUM_REGS*DATA_W  register contents.
- write_pulse  out  NUM_REGS  one-cycle pulse on commit to register i.
- rd_data  out  8  registered readback byte.
- ack_toggle  out  1  flips on every commit.
- err  out  1  sticky framing/address error.

## Operation
- Synchronisers: sel_s and strobe_s are the last stages of their chains. strobe_prev <= strobe_s. byte_ev = strobe_s ^ strobe_prev.
- The chains shift during reset, and strobe_prev follows strobe_s, so no byte_ev occurs on reset release whatever the pin level.
- State IDLE: byte_idx = 0; byte_ev is ignored.
- IDLE -> COLLECT on the cycle sel_s = 1. A byte_ev in that same cycle is ignored.
- COLLECT, on byte_ev:
  - shadow[byte_idx*8 +: 8] <= data_in.
  - If byte_idx == 0 and this is the first word of the frame, cur_addr <= addr_in.
  - byte_idx increments.
- Commit, when byte_idx == BYTES-1 at byte_ev:
  - The full word (shadow plus the current byte) is written to reg[cur_addr].
  - write_pulse[cur_addr] goes high for the following cycle; ack_toggle flips.
  - byte_idx wraps to 0; cur_addr increments, wrapping NUM_REGS-1 -> 0.
- cur_addr >= NUM_REGS at commit: no register write, no write_pulse, no ack flip; err <= 1. Auto-increment still applies.
- COLLECT -> IDLE when sel_s = 0:
  - byte_idx != 0: the partial word is discarded and err <= 1.
  - A byte_ev in the same cycle is ignored.
- Self-clear: clear_event[i] does reg[i] <= reg[i] & ~mask_i.
  - If a commit to i happens in the same cycle, the committed data wins unmasked.
- err is cleared only by reset.
- rd_data, registered every cycle: byte byte_idx of reg[ra].
  - ra = cur_addr in COLLECT, addr_in in IDLE.
  - 0 if ra >= NUM_REGS.
- Reset values:
  - Registers: RESET_VALUES.
  - write_pulse 0, ack_toggle 0, err 0, rd_data 0.
  - State IDLE, byte_idx 0, cur_addr 0.

## Timing
- Pin edge to byte_ev: SYNC_STAGES+1 cycles.
- Register update: on the clk edge ending the byte_ev cycle. write_pulse and ack_toggle are visible in the next cycle.
- Minimum spacing between strobe edges: SYNC_STAGES+2 cycles. Closer edges may merge and are not supported.
- sel_in rise to first accepted strobe edge: at least 1 cycle of separation at the pins.
- rd_data reflects a commit or byte_idx change one cycle later.
- Reset asserted mid-frame: the frame is abandoned. Registers return to RESET_VALUES; no err.

## Test plan
- Reset image: RESET_VALUES = {0x0000, 0x0700, 0x8000}, strobe_in held high through reset -> regs_out matches the image; no write_pulse; err 0; rd_data 0.
- Single write: sel=1, addr=1, bytes 0x34, 0x12 -> reg1 = 0x1234; write_pulse[1] for exactly one cycle; ack_toggle 0 -> 1; err 0.
- Burst with auto-increment and wrap: addr=1, six bytes AA BB CC DD EE FF -> reg1 = 0xBBAA, reg2 = 0xDDCC, reg0 = 0xFFEE; ack toggles 3 times.
- Errors:
  - Partial frame: one byte 0x55, then sel=0 -> no register change, err = 1.
  - After reset, addr=5 with two bytes -> no write, err = 1.
- Self-clear: CLEAR_MASK reg1 = 0x1000, reg1 = 0x1700, clear_event[1] -> 0x0700.
  - Clear coincident with a commit of 0x1234 -> 0x1234.
- Readback: IDLE, addr=2, reg2 = 0x8000 -> rd_data 0x00 one cycle later. After one byte of a frame to addr 2 -> rd_data 0x80.
